clock_enable_sequencer: RTL and testbench
=========================================

# clock_enable_sequencer

Parametrised clock-enable and reset sequencer between the clock wizard and the compute/control domains. It qualifies the wizard `locked` signal and releases per-domain synchronous resets one domain at a time with a programmable stagger. Each domain's `clock_en` is gated so it only follows its enable request once that domain is out of reset. On loss of lock it collapses all domains back into reset and re-runs the sequence.

## Interface
Parameters:
- `NUM_DOMAINS`, 4: number of sequenced domains; ≥1.
- `SYNC_STAGES`, 3: flops in the `locked` synchroniser; ≥2.
- `LOCK_FILTER`, 8: consecutive high cycles of synchronised `locked` required; ≥1.
- `STAGGER_CYCLES`, 16: cycles between successive domain releases; ≥1.

Ports:
- `root_clock`  in  1  sole clock; all state on rising edge.
- `root_rst_n`  in  1  reset; asynchronous, active-low.
- `locked`  in  1  wizard lock, asynchronous to `root_clock`.
- `en_req`  in  NUM_DOMAINS  per-domain clock-enable request from the control units, synchronous.
- `domain_rst_n`  out  NUM_DOMAINS  per-domain reset, active-low, registered.
- `clock_en`  out  NUM_DOMAINS  per-domain BUFGCE CE, registered.
- `all_ready`  out  1  high when every domain is released.
- `lock_lost`  out  1  sticky flag; set on any lock loss after first qualification.

## Operation
- Reset (`root_rst_n`=0) behaviour:
  - Asynchronously clears all state: the synchroniser, the filter counter, the stagger counter, the release index and the FSM (state `WAIT_LOCK`).
  - Outputs during reset: `domain_rst_n`=0, `clock_en`=0, `all_ready`=0, `lock_lost`=0.
  - Release of reset is synchronous through the FSM; no output changes on the deassertion edge itself.
- `locked_s` is `locked` after the `SYNC_STAGES` flop chain.
- FSM states:
  - `WAIT_LOCK`:
    - Filter counter increments while `locked_s`=1 and clears to 0 when `locked_s`=0.
    - When the counter reaches `LOCK_FILTER`, go to `RELEASE`. Clear the stagger counter and set release index = 0.
  - `RELEASE`:
    - The stagger counter counts 1..`STAGGER_CYCLES`.
    - On reaching `STAGGER_CYCLES`: set `domain_rst_n[index]`=1, increment the index and clear the counter.
    - When the index reaches `NUM_DOMAINS`, go to `RUN`.
  - `RUN`:
    - Hold all domains released. `all_ready`=1.
- Lock loss: `locked_s`=0 in `RELEASE` or `RUN` has these effects on the next edge:
  - State goes to `WAIT_LOCK`.
  - All `domain_rst_n`=0, all `clock_en`=0, `all_ready`=0.
  - `lock_lost`=1; it is cleared only by `root_rst_n`.
  - Filter and stagger counters are cleared.
- Enable gating: `clock_en[i]` is registered `en_req[i] & domain_rst_n[i]`.
  - A released domain can run during the stagger of later domains.
  - A domain in reset never receives an enable.
- Counter widths: `$clog2(max(LOCK_FILTER,STAGGER_CYCLES)+1)`. Counters saturate and never wrap. The index width is `$clog2(NUM_DOMAINS+1)`.
- Domains release strictly in ascending index order. Collapse on lock loss is simultaneous for all domains.

## Timing
- `locked` to `locked_s` latency: `SYNC_STAGES` edges.
- With `locked_s` first high at edge L:
  - `RELEASE` is entered at edge L+`LOCK_FILTER`−1.
  - `domain_rst_n[k]` rises at edge L+`LOCK_FILTER`−1+(k+1)·`STAGGER_CYCLES`.
- `all_ready` rises on the same edge as the last domain release.
- `clock_en[i]` follows `en_req[i]` with 1-cycle latency. Its first possible high is the edge after `domain_rst_n[i]` rises.
- Lock loss:
  - Collapse occurs 1 edge after `locked_s` falls, i.e. `SYNC_STAGES`+1 edges after `locked` falls.
  - `locked` low pulses shorter than the synchroniser resolution may be missed; this is acceptable.
- Simultaneous lock loss and a release event: lock loss wins; no domain releases.
- `locked_s` dropping during `WAIT_LOCK` restarts the filter from 0.

## Test plan
- Defaults, `locked`=1 from edge 0 after reset, `en_req`=0 → `domain_rst_n` bits rise at edges 26, 42, 58, 74. `all_ready`=1 at edge 74. `clock_en`=0 throughout.
- `en_req`=4'b1111 held from reset, `locked`=1 → `clock_en` sequence is:
  - 4'b0000 until edge 27.
  - 4'b0001 at 27, 4'b0011 at 43, 4'b0111 at 59, 4'b1111 at 75.
- `locked` low for 3 cycles while the filter count is 5 → filter restarts. All release edges shift by 5+3+`SYNC_STAGES`-related delay, checked against a reference model. `lock_lost` stays 0.
- In `RUN` with `en_req`=4'b1010, drop `locked` → within 4 edges `domain_rst_n`=0, `clock_en`=0, `all_ready`=0, `lock_lost`=1. Re-assert `locked` → full sequence repeats and `lock_lost` remains 1.
- Assert `root_rst_n`=0 mid-`RELEASE` (two domains released), off-edge → all outputs 0 immediately without a clock edge. After deassertion the sequence restarts from `WAIT_LOCK` and `lock_lost`=0.
- `NUM_DOMAINS`=1, `LOCK_FILTER`=1, `STAGGER_CYCLES`=1, `SYNC_STAGES`=2 → `domain_rst_n[0]` and `all_ready` rise 2 edges after `locked_s` rises. No counter wrap.

Source files
------------

// File: rtl/clock_enable_sequencer.sv
// ---------------------------------------------------------------------------
// clock_enable_sequencer
//
// Qualifies the clock wizard lock, then releases per-domain synchronous
// resets one at a time with a programmable stagger. Each domain's clock
// enable follows its request only once that domain is out of reset. Any
// loss of lock after qualification collapses every domain back into reset
// and the sequence starts over.
//
// Ports:
//   root_clock    in   sole clock, rising edge
//   root_rst_n    in   asynchronous active-low reset
//   locked        in   wizard lock, asynchronous to root_clock
//   en_req        in   per-domain clock-enable request
//   domain_rst_n  out  per-domain active-low reset (registered)
//   clock_en      out  per-domain clock enable (registered)
//   all_ready     out  every domain released
//   lock_lost     out  sticky, set on lock loss after qualification
//
// state      | meaning
// -----------+------------------------------------------------------------
// WAIT_LOCK  | all domains in reset; filtering synchronised lock
// RELEASE    | lock qualified; releasing domains in ascending order
// RUN        | all domains released; watching for lock loss
// ---------------------------------------------------------------------------
module clock_enable_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int SYNC_STAGES    = 3,
    parameter int LOCK_FILTER    = 8,
    parameter int STAGGER_CYCLES = 16
) (
    input  logic                   root_clock,
    input  logic                   root_rst_n,
    input  logic                   locked,
    input  logic [NUM_DOMAINS-1:0] en_req,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic [NUM_DOMAINS-1:0] clock_en,
    output logic                   all_ready,
    output logic                   lock_lost
);

    localparam int CMAX = (LOCK_FILTER > STAGGER_CYCLES) ? LOCK_FILTER : STAGGER_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NUM_DOMAINS + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     locked_s;
    logic [CW-1:0]            filt_cnt, filt_nxt;
    logic [CW-1:0]            stag_cnt, stag_nxt;
    logic [IW-1:0]            idx, idx_nxt;
    logic [NUM_DOMAINS-1:0]   rst_nxt;
    logic [NUM_DOMAINS-1:0]   ce_nxt;
    logic                     ready_nxt;
    logic                     lost_nxt;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge root_clock or negedge root_rst_n) begin
        if (!root_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    always_ff @(posedge root_clock or negedge root_rst_n) begin
        if (!root_rst_n) begin
            state        <= WAIT_LOCK;
            filt_cnt     <= '0;
            stag_cnt     <= '0;
            idx          <= '0;
            domain_rst_n <= '0;
            clock_en     <= '0;
            all_ready    <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state        <= state_nxt;
            filt_cnt     <= filt_nxt;
            stag_cnt     <= stag_nxt;
            idx          <= idx_nxt;
            domain_rst_n <= rst_nxt;
            clock_en     <= ce_nxt;
            all_ready    <= ready_nxt;
            lock_lost    <= lost_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        filt_nxt  = filt_cnt;
        stag_nxt  = stag_cnt;
        idx_nxt   = idx;
        rst_nxt   = domain_rst_n;
        ready_nxt = all_ready;
        lost_nxt  = lock_lost;
        // Gate with the current registered reset so an enable can only appear
        // the cycle after the domain has been released.
        ce_nxt    = en_req & domain_rst_n;

        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    if (filt_cnt != CW'(CMAX)) begin
                        filt_nxt = filt_cnt + CW'(1);
                    end
                    if (filt_nxt >= CW'(LOCK_FILTER)) begin
                        state_nxt = RELEASE;
                        stag_nxt  = '0;
                        idx_nxt   = '0;
                    end
                end else begin
                    filt_nxt = '0;
                end
            end

            RELEASE, RUN: begin
                if (!locked_s) begin
                    // Lock loss takes priority over any release due this edge.
                    state_nxt = WAIT_LOCK;
                    rst_nxt   = '0;
                    ce_nxt    = '0;
                    ready_nxt = 1'b0;
                    lost_nxt  = 1'b1;
                    filt_nxt  = '0;
                    stag_nxt  = '0;
                    idx_nxt   = '0;
                end else if (state == RELEASE) begin
                    if (stag_cnt != CW'(CMAX)) begin
                        stag_nxt = stag_cnt + CW'(1);
                    end
                    if (stag_nxt == CW'(STAGGER_CYCLES)) begin
                        stag_nxt = '0;
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            if (idx == IW'(i)) begin
                                rst_nxt[i] = 1'b1;
                            end
                        end
                        idx_nxt = idx + IW'(1);
                        if (idx_nxt == IW'(NUM_DOMAINS)) begin
                            state_nxt = RUN;
                            ready_nxt = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
    end

endmodule

// File: tb/tb_clock_enable_sequencer.sv
module tb_clock_enable_sequencer;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic [3:0] en_req;
    logic [3:0] domain_rst_n;
    logic [3:0] clock_en;
    logic       all_ready;
    logic       lock_lost;

    logic       s_rst_n;
    logic       s_locked;
    logic [0:0] s_en_req;
    logic [0:0] s_domain_rst_n;
    logic [0:0] s_clock_en;
    logic       s_all_ready;
    logic       s_lock_lost;

    int edge_n;
    int checks;
    int failures;

    clock_enable_sequencer u_dut (
        .root_clock   (clk),
        .root_rst_n   (rst_n),
        .locked       (locked),
        .en_req       (en_req),
        .domain_rst_n (domain_rst_n),
        .clock_en     (clock_en),
        .all_ready    (all_ready),
        .lock_lost    (lock_lost)
    );

    clock_enable_sequencer #(
        .NUM_DOMAINS    (1),
        .SYNC_STAGES    (2),
        .LOCK_FILTER    (1),
        .STAGGER_CYCLES (1)
    ) u_dut_small (
        .root_clock   (clk),
        .root_rst_n   (s_rst_n),
        .locked       (s_locked),
        .en_req       (s_en_req),
        .domain_rst_n (s_domain_rst_n),
        .clock_en     (s_clock_en),
        .all_ready    (s_all_ready),
        .lock_lost    (s_lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Domain k is released at base + 16*k with the default stagger.
    function automatic logic [3:0] exp_rel(input int n, input int base);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (n >= base + 16 * k);
        return r;
    endfunction

    task automatic start_run(input logic [3:0] en);
        rst_n  = 1'b0;
        locked = 1'b1;
        en_req = en;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_domain", 32'(domain_rst_n), 32'h0);
        check_val("rst_ce", 32'(clock_en), 32'h0);
        check_val("rst_ready", 32'(all_ready), 32'h0);
        check_val("rst_lost", 32'(lock_lost), 32'h0);
        rst_n  = 1'b1;
        edge_n = -1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        edge_n   = -1;
        rst_n    = 1'b0;
        locked   = 1'b0;
        en_req   = 4'h0;
        s_rst_n  = 1'b0;
        s_locked = 1'b0;
        s_en_req = 1'b1;

        // Run A: plain sequence, no enables requested.
        start_run(4'h0);
        repeat (81) begin
            tick();
            check_val("a_domain", 32'(domain_rst_n), 32'(exp_rel(edge_n, 26)));
            check_val("a_ce", 32'(clock_en), 32'h0);
            check_val("a_ready", 32'(all_ready), 32'(edge_n >= 74));
        end

        // Lock loss in RUN, then relock.
        en_req = 4'b1010;
        tick();
        check_val("run_ce", 32'(clock_en), 32'hA);
        tick();
        locked = 1'b0;
        repeat (3) tick();
        check_val("pre_loss_domain", 32'(domain_rst_n), 32'hF);
        check_val("pre_loss_lost", 32'(lock_lost), 32'h0);
        tick();
        check_val("loss_domain", 32'(domain_rst_n), 32'h0);
        check_val("loss_ce", 32'(clock_en), 32'h0);
        check_val("loss_ready", 32'(all_ready), 32'h0);
        check_val("loss_lost", 32'(lock_lost), 32'h1);
        repeat (4) tick();
        locked = 1'b1;
        while (edge_n < 166) begin
            tick();
            check_val("relock_domain", 32'(domain_rst_n), 32'(exp_rel(edge_n, 117)));
        end
        check_val("relock_ready", 32'(all_ready), 32'h1);
        check_val("relock_lost", 32'(lock_lost), 32'h1);
        check_val("relock_ce", 32'(clock_en), 32'hA);

        // Run B: all enables requested; enables trail releases by one edge.
        start_run(4'hF);
        repeat (81) begin
            tick();
            check_val("b_ce", 32'(clock_en), 32'(exp_rel(edge_n, 27)));
        end

        // Run C: async reset mid-release.
        start_run(4'hF);
        repeat (46) tick();
        check_val("c_domain_mid", 32'(domain_rst_n), 32'h3);
        check_val("c_ce_mid", 32'(clock_en), 32'h3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("c_async_domain", 32'(domain_rst_n), 32'h0);
        check_val("c_async_ce", 32'(clock_en), 32'h0);
        check_val("c_async_ready", 32'(all_ready), 32'h0);
        check_val("c_async_lost", 32'(lock_lost), 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = -1;
        repeat (28) begin
            tick();
            check_val("c_domain", 32'(domain_rst_n), 32'(exp_rel(edge_n, 26)));
        end
        check_val("c_ce", 32'(clock_en), 32'h1);
        check_val("c_lost", 32'(lock_lost), 32'h0);

        // Run D: lock glitch while filter count is 5 restarts the filter.
        start_run(4'h0);
        repeat (84) begin
            tick();
            if (edge_n == 4) locked = 1'b0;
            if (edge_n == 7) locked = 1'b1;
            check_val("d_domain", 32'(domain_rst_n), 32'(exp_rel(edge_n, 34)));
        end
        check_val("d_ready", 32'(all_ready), 32'h1);
        check_val("d_lost", 32'(lock_lost), 32'h0);

        // Minimal configuration.
        check_val("s_rst_domain", 32'(s_domain_rst_n), 32'h0);
        s_locked = 1'b1;
        @(negedge clk);
        s_rst_n = 1'b1;
        edge_n  = -1;
        repeat (8) begin
            tick();
            check_val("s_domain", 32'(s_domain_rst_n), 32'(edge_n >= 3));
            check_val("s_ready", 32'(s_all_ready), 32'(edge_n >= 3));
            check_val("s_ce", 32'(s_clock_en), 32'(edge_n >= 4));
        end
        check_val("s_lost", 32'(s_lock_lost), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
